// File: rtl/lz77_pkg.sv
// lz77_pkg: shared states, default widths and token type for the LZ77 decoder
package lz77_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int SB_DEPTH_DEF = 9;
  localparam int POS_W_DEF = 4;
  localparam int LEN_W_DEF = 3;
  localparam logic [DATA_W_DEF-1:0] END_CHAR_DEF = 8'h24;
  typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;
  typedef struct packed {
    logic [POS_W_DEF-1:0] pos;
    logic [LEN_W_DEF-1:0] len;
    logic [DATA_W_DEF-1:0] chr;
  } token_t;
endpackage

// File: rtl/lz77_search_buffer.sv
// lz77_search_buffer: clearable shift-register history with guarded indexed read
module lz77_search_buffer import lz77_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int POS_W = POS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  input  logic [POS_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  localparam logic [POS_W:0] DEPTH_C = SB_DEPTH[POS_W:0];
  logic [DATA_W-1:0] buf_q [SB_DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SB_DEPTH; i++) buf_q[i] <= '0;
    end else if (shift_en) begin
      buf_q[0] <= din;
      for (int i = 1; i < SB_DEPTH; i++) buf_q[i] <= buf_q[i-1];
    end
  end
  assign rd_data = ({1'b0, rd_idx} < DEPTH_C) ? buf_q[rd_idx] : '0;
endmodule

// File: rtl/lz77_stream_decoder.sv
// lz77_stream_decoder: expands (pos, len, char) tokens into a backpressured symbol stream
module lz77_stream_decoder import lz77_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter logic [DATA_W-1:0] END_CHAR = END_CHAR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [POS_W-1:0]  code_pos,
  input  logic [LEN_W-1:0]  code_len,
  input  logic [DATA_W-1:0] chardata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] char_nxt,
  output logic              finish,
  output logic              pos_err
);
  localparam logic [POS_W:0] DEPTH_C = SB_DEPTH[POS_W:0];
  state_t state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W-1:0] chr_q, chr_d, char_nxt_q, char_nxt_d, rd_data, sym;
  logic tok_ready_q, tok_ready_d, out_valid_q, out_valid_d;
  logic finish_q, finish_d, pos_err_q, pos_err_d;
  logic slot, accept, emit, last_copy, is_end;
  lz77_search_buffer #(.DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH), .POS_W(POS_W)) u_sb (
    .clk(clk), .reset(reset), .shift_en(emit), .din(sym), .rd_idx(pos_q), .rd_data(rd_data)
  );
  always_comb begin
    slot = !out_valid_q || out_ready;
    accept = tok_ready_q && tok_valid;
    emit = slot && (state_q == COPY || state_q == LIT);
    sym = (state_q == COPY) ? rd_data : chr_q;
    last_copy = cnt_q == len_q - LEN_W'(1);
    is_end = chr_q == END_CHAR;
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? ((code_len != '0) ? COPY : LIT) : IDLE;
      COPY: state_d = (slot && last_copy) ? LIT : COPY;
      LIT:  state_d = slot ? (is_end ? DONE : IDLE) : LIT;
      default: state_d = DONE;
    endcase
    pos_d = accept ? code_pos : pos_q;
    len_d = accept ? code_len : len_q;
    chr_d = accept ? chardata : chr_q;
    cnt_d = accept ? '0 : (state_q == COPY && slot) ? cnt_q + LEN_W'(1) : cnt_q;
    char_nxt_d = emit ? sym : char_nxt_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    tok_ready_d = state_d == IDLE;
    finish_d = finish_q || (state_q == LIT && slot && is_end);
    pos_err_d = pos_err_q || (accept && {1'b0, code_pos} >= DEPTH_C);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q <= '0;
      len_q <= '0;
      chr_q <= '0;
      cnt_q <= '0;
      char_nxt_q <= '0;
      out_valid_q <= 1'b0;
      tok_ready_q <= 1'b0;
      finish_q <= 1'b0;
      pos_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      len_q <= len_d;
      chr_q <= chr_d;
      cnt_q <= cnt_d;
      char_nxt_q <= char_nxt_d;
      out_valid_q <= out_valid_d;
      tok_ready_q <= tok_ready_d;
      finish_q <= finish_d;
      pos_err_q <= pos_err_d;
    end
  end
  assign tok_ready = tok_ready_q;
  assign out_valid = out_valid_q;
  assign char_nxt = char_nxt_q;
  assign finish = finish_q;
  assign pos_err = pos_err_q;
endmodule

// File: doc/lz77_stream_decoder.md
# lz77_stream_decoder

Parametrised LZ77 token decoder with valid/ready handshakes on both sides. Each input token (code_pos, code_len, chardata) expands to code_len bytes copied from a sliding search buffer, followed by one literal byte. It sits between the token source and the byte sink in the LZ77 datapath. It succeeds the fixed 9-entry, free-running decoder with configurable widths and depth, output backpressure, a position-error flag and a clean terminate/reset protocol.

## Interface
- DATA_W, 8: symbol width.
- SB_DEPTH, 9: search-buffer entries; valid positions are 0..SB_DEPTH-1.
- POS_W, 4: code_pos width; must satisfy 2^POS_W >= SB_DEPTH.
- LEN_W, 3: code_len width; maximum copy length is 2^LEN_W-1.
- END_CHAR, 8'h24: terminator literal.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tok_valid  in  1  token present.
- tok_ready  out  1  decoder accepts a token this cycle.
- code_pos  in  POS_W  copy distance; 0 = most recently emitted symbol.
- code_len  in  LEN_W  number of symbols to copy.
- chardata  in  DATA_W  literal emitted after the copy.
- out_valid  out  1  char_nxt holds a symbol.
- out_ready  in  1  sink takes the symbol.
- char_nxt  out  DATA_W  decoded symbol (registered).
- finish  out  1  terminator emitted; sticky until reset.
- pos_err  out  1  sticky; a token had code_pos >= SB_DEPTH.

## Operation
- **Reset values:** tok_ready=0, out_valid=0, char_nxt=0, finish=0, pos_err=0. Search buffer cleared to 0; state IDLE.
- **Emit slot:** a slot is free when `!out_valid || out_ready`. Every emission does three things together: it registers the symbol into char_nxt, sets out_valid, and shifts it into buffer entry 0 (entry k moves to k+1, and the oldest entry is dropped).
- **If no symbol is emitted and out_ready=1:** out_valid clears.
- **IDLE:** tok_ready=1. On accept, latch pos, len and char and clear cnt. Go to COPY if len!=0, otherwise to LIT.
- **COPY:** tok_ready=0. On a free slot:
  - emit buffer[pos] and increment cnt;
  - when cnt==len-1, go to LIT.
  - Positions are read from the live, shifting buffer, so overlapping copies (pos < len) replicate data, as LZ77 requires.
- **LIT:** tok_ready=0. On a free slot:
  - emit the latched char;
  - go to DONE if char==END_CHAR (set finish in the same edge), otherwise go to IDLE.
- **DONE:** tok_ready=0 and no further emissions. The final symbol stays valid until out_ready; finish stays 1 until reset.
- **Bad position** (pos >= SB_DEPTH): set pos_err at accept. Each copy symbol of that token is emitted as 0; the remaining decode is unaffected.
- **Arithmetic:** cnt is LEN_W bits and never wraps, because cnt < len <= 2^LEN_W-1. Position compare is unsigned.

## Timing
- Token accepted at edge E: the first symbol is visible (out_valid=1) after edge E+1. Latency is 1 cycle with no stall.
- Throughput is one symbol per cycle under continuous out_ready, plus one IDLE cycle per token. A token of length L occupies L+2 cycles.
- While out_valid=1 and out_ready=0, char_nxt is held stable, state and buffer are frozen, and tok_ready stays 0 outside IDLE.
- reset asserted in any state at any cycle: the values above apply after that edge. Any pending output is discarded, and no handshake completes in the reset cycle.
- tok_valid with tok_ready=0 has no effect. Token inputs need to be stable only in the accept cycle.

## Structure
- Package lz77_pkg holds the state enum {IDLE, COPY, LIT, DONE}, default widths, default END_CHAR, and a token struct {pos, len, char} parameterised via localparams.
- Sub-module lz77_search_buffer: a SB_DEPTH x DATA_W shift register with shift-in enable, synchronous clear, and a combinational indexed read port that returns 0 for out-of-range indexes.
- The top level contains the FSM, token latch, cnt, output register and flags.

## Test plan
- **Reset then token (0,0,0x61), out_ready=1:** one cycle after accept, char_nxt=0x61 and out_valid=1. tok_ready returns 1 in the following cycle.
- **After 0x61, token (0,3,0x62):** output 0x61,0x61,0x61,0x62 on consecutive cycles (overlap copy).
- **Prime with 0x41,0x42,0x43, then token (2,2,0x24):** output 0x41,0x42,0x24. finish=1 on the edge that emits 0x24, tok_ready stays 0 afterwards, and finish holds until reset.
- **Token (0,3,0x62) with out_ready toggling 1,0,0,1,...:** every symbol appears exactly once with char_nxt stable while stalled. The sequence matches the unstalled case.
- **Token (SB_DEPTH,2,0x63):** pos_err=1 after accept; output 0x00,0x00,0x63; pos_err remains 1.
- **Reset asserted mid-COPY:** next cycle all outputs are at reset values. A subsequent token (0,1,0x70) outputs 0x00,0x70 because the buffer was cleared.
